// File: rtl/a_lock_sequencer.sv
// a_lock_sequencer: keypad session controller for the digital lock.
// Assembles four digits into a candidate code, starts the checker compare,
// samples its result after a fixed latency, then times the unlocked window,
// counts failed attempts and times the lockout period.
module a_lock_sequencer #(
   parameter int MAX_ERR        = 3,
   parameter int CHECK_LAT      = 2,
   parameter int UNLOCK_CYCLES  = 500,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        clear,
   input  logic        relock,
   input  logic        enb_lock,
   output logic [15:0] pw_16bit,
   output logic        enough,
   output logic        chk_rst,
   output logic        unlocked,
   output logic        locked_out,
   output logic [2:0]  error_counter,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_LOCKOUT
   } state_t;

   state_t             state, state_nxt;
   logic [2:0]         cnt, cnt_nxt;
   logic [CNT_W-1:0]   tmr, tmr_nxt;
   logic [15:0]        pw_nxt;
   logic [2:0]         err_nxt;
   logic               enough_nxt, chk_rst_nxt;
   logic [3:0]         err_inc;

   // Widened so the compare against MAX_ERR cannot overflow at MAX_ERR=7.
   assign err_inc = {1'b0, error_counter} + 4'd1;

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         tmr           <= '0;
         pw_16bit      <= '0;
         error_counter <= '0;
         enough        <= 1'b0;
         chk_rst       <= 1'b0;
         unlocked      <= 1'b0;
         locked_out    <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         tmr           <= tmr_nxt;
         pw_16bit      <= pw_nxt;
         error_counter <= err_nxt;
         enough        <= enough_nxt;
         chk_rst       <= chk_rst_nxt;
         unlocked      <= (state_nxt == S_UNLOCKED);
         locked_out    <= (state_nxt == S_LOCKOUT);
         busy          <= (state_nxt == S_CHECK) || (state_nxt == S_UNLOCKED) ||
                          (state_nxt == S_LOCKOUT);
      end
   end

   // Next-state and next-output decode; pulses default low every cycle.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      tmr_nxt     = tmr;
      pw_nxt      = pw_16bit;
      err_nxt     = error_counter;
      enough_nxt  = 1'b0;
      chk_rst_nxt = 1'b0;
      case (state)
         S_IDLE, S_ENTRY: begin
            // clear wins over a digit arriving in the same cycle
            if (clear) begin
               pw_nxt    = '0;
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else if (digit_valid) begin
               pw_nxt = {pw_16bit[11:0], digit};
               if (cnt == 3'd3) begin
                  cnt_nxt    = '0;
                  tmr_nxt    = '0;
                  enough_nxt = 1'b1;
                  state_nxt  = S_CHECK;
               end else begin
                  cnt_nxt   = cnt + 3'd1;
                  state_nxt = S_ENTRY;
               end
            end
         end
         S_CHECK: begin
            // tmr counts cycles since the enough cycle; the result is taken
            // on the cycle that is CHECK_LAT cycles after it
            if (tmr == CNT_W'(CHECK_LAT)) begin
               pw_nxt = '0;
               if (enb_lock) begin
                  err_nxt   = '0;
                  tmr_nxt   = CNT_W'(UNLOCK_CYCLES);
                  state_nxt = S_UNLOCKED;
               end else if (err_inc < 4'(MAX_ERR)) begin
                  err_nxt   = err_inc[2:0];
                  tmr_nxt   = '0;
                  state_nxt = S_IDLE;
               end else begin
                  err_nxt   = 3'(MAX_ERR);
                  tmr_nxt   = CNT_W'(LOCKOUT_CYCLES);
                  state_nxt = S_LOCKOUT;
               end
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_UNLOCKED: begin
            if (tmr <= CNT_W'(1) || relock) begin
               tmr_nxt     = '0;
               chk_rst_nxt = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         S_LOCKOUT: begin
            // keypad, clear and relock are all ignored here
            if (tmr <= CNT_W'(1)) begin
               tmr_nxt     = '0;
               err_nxt     = '0;
               chk_rst_nxt = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
